// File: rtl/arith_pkg.sv
// Shared encodings and saturation helpers for the registered execute-stage arithmetic unit.
package arith_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Largest positive two's-complement value of the given width, zero-extended.
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
module mul_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_r;

  // Iteration engine; done stays high until the next start so the parent can sample it late.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, mag_a};
      mplier_r <= mag_b;
      cnt_r    <= '0;
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      if (cnt_r == CW'(WIDTH - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/arith_unit_p.sv
// Registered ADD/SUB/XOR/ANDN/MUL unit with valid/ready handshakes, overflow
// detection and optional saturation; MUL runs on a multi-cycle shift-add engine.
module arith_unit_p #(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             sign,
  input  logic             sat,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ofl,
  output logic             cout,
  output logic             err
);

  import arith_pkg::*;

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  state_t             state_r, state_nxt_s;
  logic               out_valid_r, ofl_r, cout_r, err_r;
  logic [WIDTH-1:0]   out_r;
  logic               slot_free_s, in_ready_s, accept_s, load_alu_s, load_mul_s, mul_start_s;
  logic               sat_en_s, mul_done_s;
  logic [WIDTH:0]     add_full_s, sub_full_s;
  logic [WIDTH-1:0]   alu_out_s, alu_satv_s, alu_res_s;
  logic               alu_ofl_s, alu_cout_s, alu_err_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic               mneg_r, msigned_r, msat_r;
  logic [2*WIDTH-1:0] prod_mag_s, mul_full_s;
  logic [WIDTH:0]     mul_hi_s;
  logic [WIDTH-1:0]   mul_satv_s, mul_res_s;
  logic               mul_ofl_s;

  assign slot_free_s = !out_valid_r || out_ready;
  assign in_ready_s  = rst && (state_r == IDLE) && slot_free_s;
  assign accept_s    = in_valid && in_ready_s;
  assign load_alu_s  = accept_s && (op != OP_MUL);
  assign sat_en_s    = SAT_EN & sat;

  assign add_full_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign sub_full_s = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle datapath: raw result, carry, overflow and saturation target per opcode.
  always_comb begin
    alu_out_s  = '0;
    alu_satv_s = '0;
    alu_ofl_s  = 1'b0;
    alu_cout_s = 1'b0;
    alu_err_s  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_out_s  = add_full_s[M:0];
        alu_cout_s = add_full_s[WIDTH];
        if (sign) begin
          alu_ofl_s  = (A[M] == B[M]) && (add_full_s[M] != A[M]);
          alu_satv_s = A[M] ? SAT_MIN : SAT_MAX;
        end else begin
          alu_ofl_s  = add_full_s[WIDTH];
          alu_satv_s = '1;
        end
      end
      OP_SUB: begin
        alu_out_s  = sub_full_s[M:0];
        alu_cout_s = sub_full_s[WIDTH];
        if (sign) begin
          alu_ofl_s  = (A[M] != B[M]) && (sub_full_s[M] != A[M]);
          alu_satv_s = A[M] ? SAT_MIN : SAT_MAX;
        end else begin
          alu_ofl_s  = !sub_full_s[WIDTH];
          alu_satv_s = '0;
        end
      end
      OP_XOR:  alu_out_s = A ^ B;
      OP_ANDN: alu_out_s = A & ~B;
      OP_MUL:  alu_err_s = 1'b0;
      default: alu_err_s = 1'b1;
    endcase
  end

  assign alu_res_s = (sat_en_s && alu_ofl_s) ? alu_satv_s : alu_out_s;

  // The engine multiplies magnitudes; the sign is restored after it finishes.
  assign mag_a_s = (sign && A[M]) ? ('0 - A) : A;
  assign mag_b_s = (sign && B[M]) ? ('0 - B) : B;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .mag_a   (mag_a_s),
    .mag_b   (mag_b_s),
    .done    (mul_done_s),
    .product (prod_mag_s)
  );

  // Remember how to fix up the product once the engine is done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mneg_r    <= 1'b0;
      msigned_r <= 1'b0;
      msat_r    <= 1'b0;
    end else if (mul_start_s) begin
      mneg_r    <= sign && (A[M] ^ B[M]);
      msigned_r <= sign;
      msat_r    <= sat_en_s;
    end
  end

  assign mul_full_s = mneg_r ? ('0 - prod_mag_s) : prod_mag_s;
  assign mul_hi_s   = mul_full_s[2*WIDTH-1:M];
  assign mul_ofl_s  = msigned_r ? !((&mul_hi_s) || (~|mul_hi_s)) : (|mul_full_s[2*WIDTH-1:WIDTH]);
  assign mul_satv_s = msigned_r ? (mneg_r ? SAT_MIN : SAT_MAX) : '1;
  assign mul_res_s  = (msat_r && mul_ofl_s) ? mul_satv_s : mul_full_s[M:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state, engine start and DONE unload (waits while the output slot is full).
  always_comb begin
    state_nxt_s = state_r;
    mul_start_s = 1'b0;
    load_mul_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (op == OP_MUL)) begin
          state_nxt_s = MUL;
          mul_start_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MUL;
        end
      end
      DONE: begin
        if (slot_free_s) begin
          load_mul_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output slot: a new result may replace one being consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
      ofl_r       <= 1'b0;
      cout_r      <= 1'b0;
      err_r       <= 1'b0;
    end else if (load_alu_s) begin
      out_valid_r <= 1'b1;
      out_r       <= alu_res_s;
      ofl_r       <= alu_ofl_s;
      cout_r      <= alu_cout_s;
      err_r       <= alu_err_s;
    end else if (load_mul_s) begin
      out_valid_r <= 1'b1;
      out_r       <= mul_res_s;
      ofl_r       <= mul_ofl_s;
      cout_r      <= 1'b0;
      err_r       <= 1'b0;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign ofl       = ofl_r;
  assign cout      = cout_r;
  assign err       = err_r;

endmodule

// File: doc/arith_unit_p.md
Name: arith_unit_p

Overview:
- Parametrised, registered successor to the 16-bit combinational arith block in the execute stage.
- Adds:
  - generic WIDTH;
  - a valid/ready handshake on input and output;
  - a multi-cycle shift-add multiply;
  - signed/unsigned overflow detection for every arithmetic op;
  - optional saturation.
- Sits between the decode/issue register and the writeback mux.
- Stalls issue while a multiply is in flight.

Parameters:
- WIDTH, 16, operand/result width (>= 4).
- SAT_EN, 1, 1 = honour sat input; 0 = sat ignored, always wrap.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  000 ADD, 001 SUB, 010 XOR, 011 ANDN (A & ~B), 100 MUL, 101-111 reserved.
- sign  input  1  1 = two's-complement overflow rules, 0 = unsigned.
- sat  input  1  saturate the result on overflow.
- cin  input  1  carry-in, ADD only; ignored otherwise.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- ofl  output  1  overflow flag for out.
- cout  output  1  raw carry out (ADD/SUB), 0 otherwise.
- err  output  1  reserved opcode was accepted.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = IDLE;
  - out_valid = 0, out = 0, ofl = 0, cout = 0, err = 0;
  - in_ready = 0 during the reset cycle;
  - an in-flight multiply is abandoned and no result is produced.
- Accept: in_valid && in_ready at a clock edge. Operands, op, sign, sat and cin are captured.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational and allows back-to-back single-cycle ops at full throughput.
- States:
  - IDLE:
    - accept of ADD/SUB/XOR/ANDN: result registered, out_valid = 1 next cycle (latency 1), stay in IDLE.
    - accept of MUL: go to MUL, counter = 0.
    - accept of reserved op: out = 0, ofl = 0, err = 1, latency 1.
  - MUL:
    - one multiplier bit per cycle, LSB first, on magnitudes. For signed, the operands are negated first if negative.
    - 2*WIDTH-bit accumulator.
    - after WIDTH iterations go to DONE.
  - DONE:
    - apply the sign fix-up, overflow and saturation.
    - load the output register, set out_valid = 1, go to IDLE.
    - MUL latency = WIDTH + 2 cycles from accept to out_valid.
- Output hold: out/ofl/cout/err stay stable while out_valid && !out_ready. They clear to out_valid = 0 on the handshake unless a new result is loaded in the same cycle.
- A MUL in DONE with the output slot still full waits in DONE. No result is ever dropped or overwritten.
- ADD (R = A + B + cin, cout = carry out of MSB):
  - signed ofl = (A[msb] == B[msb]) && (R[msb] != A[msb]);
  - unsigned ofl = cout.
- SUB (R = A + ~B + 1):
  - signed ofl = (A[msb] != B[msb]) && (R[msb] != A[msb]);
  - unsigned ofl = !cout (borrow).
- XOR/ANDN: ofl = 0, cout = 0.
- MUL: out = low WIDTH bits of the product.
  - unsigned ofl = high half != 0.
  - signed ofl = full product is not the sign-extension of the low half.
- Saturation, when sat && SAT_EN && ofl:
  - signed: positive overflow -> 0111..1, negative overflow -> 1000..0. Direction is the true result sign: A[msb] for ADD/SUB, sign(A) XOR sign(B) for MUL.
  - unsigned: ADD/MUL -> all ones, SUB -> 0.
  - ofl stays 1 when saturated.
- Edge cases:
  - signed MUL of most-negative by -1 overflows and saturates to max positive.
  - in_valid while busy is ignored (in_ready = 0); upstream must hold it.

Decomposition:
- Package arith_pkg holds:
  - op encodings OP_ADD..OP_MUL as 3-bit localparams;
  - state encodings IDLE/MUL/DONE;
  - functions sat_max(width) / sat_min(width).
- One sub-module: mul_shift_add (WIDTH param; start, done, magnitude in/out).
  - It owns the iteration counter and accumulator.
  - Sign handling, overflow and saturation stay in the parent.

Test Plan:
- WIDTH=16, ADD signed, A=0x7FFF, B=0x0001, sat=0 -> out=0x8000, ofl=1, out_valid one cycle after accept. Same with sat=1 -> out=0x7FFF, ofl=1.
- SUB unsigned, A=0x0003, B=0x0005, sat=1 -> out=0x0000, ofl=1, cout=0. With sat=0 -> out=0xFFFE, ofl=1.
- MUL signed, A=0xFFFD (-3), B=0x0007 -> out=0xFFEB (-21), ofl=0, out_valid exactly 18 cycles after accept, in_ready=0 throughout. A=0x8000, B=0xFFFF, sat=1 -> out=0x7FFF, ofl=1.
- Back-to-back XOR/ANDN with out_ready=1 -> one result per cycle. Hold out_ready=0 for 3 cycles -> out stable, in_ready=0, nothing lost, results in order.
- Assert rst low mid-MUL (cycle 8) -> next cycle out_valid=0, state IDLE. Following ADD 0x0002+0x0003 with cin=1 -> out=0x0006.
- Reserved op 3'b110 -> err=1, out=0, ofl=0 after 1 cycle. The next valid op clears err.
